// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one fixed-latency cordic (y*2^-x)
// pipeline between NREQ requesters, with an ID tag pipe that routes each
// result back on a shared response bus.

`ifndef SVM_CORDIC_WIDTH
`define SVM_CORDIC_WIDTH 16
`endif
`ifndef SVM_CORDIC_STEPS
`define SVM_CORDIC_STEPS 8
`endif

module cordic_arbiter #(
   parameter int NREQ    = 4,
   parameter int ID_W    = 2,
   parameter int WIDTH   = `SVM_CORDIC_WIDTH,
   parameter int LATENCY = `SVM_CORDIC_STEPS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_x,
   input  logic [NREQ*WIDTH-1:0] req_y,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       cfg_mask,
   input  logic                  hold,
   output logic [WIDTH-1:0]      cordic_x,
   output logic [WIDTH-1:0]      cordic_y,
   output logic                  cordic_enable,
   input  logic [WIDTH-1:0]      cordic_result,
   input  logic                  cordic_valid_nxt,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  busy,
   output logic                  err
);

   logic [NREQ-1:0]  w_eligible;
   logic             w_found_hi;
   logic [ID_W-1:0]  w_id_hi;
   logic             w_found_lo;
   logic [ID_W-1:0]  w_id_lo;
   logic             w_transfer;
   logic [ID_W-1:0]  w_gnt_id;
   logic [NREQ-1:0]  w_ready;
   logic [WIDTH-1:0] w_sel_x;
   logic [WIDTH-1:0] w_sel_y;

   logic [ID_W-1:0]  r_ptr;
   logic [ID_W-1:0]  r_issue_id;
   logic             r_cordic_en;
   logic [WIDTH-1:0] r_cordic_x;
   logic [WIDTH-1:0] r_cordic_y;
   logic [LATENCY:1] r_tag_v;
   logic [ID_W-1:0]  r_tag_id [1:LATENCY];
   logic             r_rsp_valid;
   logic [ID_W-1:0]  r_rsp_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_err;

   // Round-robin grant: the lowest eligible lane above the pointer wins,
   // otherwise wrap to the lowest eligible lane overall. The descending scan
   // lets the lowest index overwrite higher ones.
   always_comb begin
      w_eligible = hold ? '0 : (req_valid & cfg_mask);
      w_found_hi = 1'b0;
      w_id_hi    = '0;
      w_found_lo = 1'b0;
      w_id_lo    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_found_lo = 1'b1;
            w_id_lo    = ID_W'(i);
            if (i > int'(r_ptr)) begin
               w_found_hi = 1'b1;
               w_id_hi    = ID_W'(i);
            end
         end
      end
      w_transfer = w_found_lo;
      w_gnt_id   = w_found_hi ? w_id_hi : w_id_lo;
      w_ready    = '0;
      if (w_transfer) begin
         w_ready[w_gnt_id] = 1'b1;
      end
   end

   // Operand mux for the granted lane.
   always_comb begin
      w_sel_x = '0;
      w_sel_y = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_ready[i]) begin
            w_sel_x = req_x[i*WIDTH +: WIDTH];
            w_sel_y = req_y[i*WIDTH +: WIDTH];
         end
      end
   end

   // Issue stage: launch the granted operands into the cordic and advance the pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr       <= ID_W'(NREQ - 1);
         r_issue_id  <= '0;
         r_cordic_en <= 1'b0;
         r_cordic_x  <= '0;
         r_cordic_y  <= '0;
      end else begin
         r_cordic_en <= w_transfer;
         if (w_transfer) begin
            r_ptr      <= w_gnt_id;
            r_issue_id <= w_gnt_id;
            r_cordic_x <= w_sel_x;
            r_cordic_y <= w_sel_y;
         end
      end
   end

   // Tag pipe: follows each operation through the cordic, one stage per cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tag_v <= '0;
         for (int k = 1; k <= LATENCY; k++) begin
            r_tag_id[k] <= '0;
         end
      end else begin
         r_tag_v     <= {r_tag_v[LATENCY-1:1], r_cordic_en};
         r_tag_id[1] <= r_issue_id;
         for (int k = 2; k <= LATENCY; k++) begin
            r_tag_id[k] <= r_tag_id[k-1];
         end
      end
   end

   // Response register: capture the cordic result when the tag reaches the end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= r_tag_v[LATENCY];
         if (r_tag_v[LATENCY]) begin
            r_rsp_id   <= r_tag_id[LATENCY];
            r_rsp_data <= cordic_result;
         end
      end
   end

   // Sticky error when the cordic's own valid disagrees with our tag pipe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (r_tag_v[LATENCY-1] != cordic_valid_nxt) begin
         r_err <= 1'b1;
      end
   end

   assign req_ready     = w_ready;
   assign cordic_x      = r_cordic_x;
   assign cordic_y      = r_cordic_y;
   assign cordic_enable = r_cordic_en;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_id        = r_rsp_id;
   assign rsp_data      = r_rsp_data;
   assign err           = r_err;
   assign busy          = (|r_tag_v) | r_cordic_en | r_rsp_valid;

endmodule
